// File: rtl/sync_updown_modn_counter.sv
// Synchronous modulo-MODULUS up/down counter with load, terminal count and sticky wrap flag.
// Optional Gray-coded output enabled by defining COUNTER_GRAY_EN.
module sync_updown_modn_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap_flag
`ifdef COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] Q_gray
`endif
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
    $fatal(1, "sync_updown_modn_counter: illegal MODULUS/RESET_VAL for WIDTH");
  end

  // Extra bit keeps MODULUS-1 and Q+1 representable when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MAX_V = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_flag_q, wrap_flag_d;
  logic [WIDTH:0]   q_ext, ld_ext, nxt;
  logic             at_max, at_zero;

  assign q_ext   = {1'b0, q_q};
  assign ld_ext  = {1'b0, load_val};
  assign at_max  = (q_ext == MAX_V);
  assign at_zero = (q_q == '0);

  assign tc = ~clear & en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    nxt = q_ext;
    if (load)       nxt = (ld_ext > MAX_V) ? MAX_V : ld_ext;
    else if (en) begin
      if (up_dn)    nxt = at_max  ? '0    : q_ext + 1'b1;
      else          nxt = at_zero ? MAX_V : q_ext - 1'b1;
    end
    q_d = nxt[WIDTH-1:0];
  end

  // Set beats clear when both happen on the same edge.
  always_comb begin
    wrap_flag_d = wrap_flag_q;
    if (clr_flag) wrap_flag_d = 1'b0;
    if (tc)       wrap_flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q_q         <= RST_V;
      wrap_flag_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      wrap_flag_q <= wrap_flag_d;
    end
  end

  assign Q         = q_q;
  assign wrap_flag = wrap_flag_q;

`ifdef COUNTER_GRAY_EN
  logic [WIDTH-1:0] q_gray_q, q_gray_d;

  // Encode the next count so the Gray register tracks Q with no added latency.
  assign q_gray_d = q_d ^ (q_d >> 1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) q_gray_q <= RST_V ^ (RST_V >> 1);
    else       q_gray_q <= q_gray_d;
  end

  assign Q_gray = q_gray_q;
`endif

endmodule
